// File: rtl/dc_mem_responder_if.sv
// Data-cache tiny-AXI bus between the LSU-stage D-cache (master) and the
// memory responder (slave).
//   dcw_*            : line writeback request and write-complete pulse
//   dcr_* / rqfull_1 : line-fill read request and requester backpressure
//   rdat_m_*         : read line data and its valid pulse
//   finish_mrd       : read transaction finished pulse
//   busy / ovf_err   : responder status
interface dc_mem_responder_if;
  logic         dcw_start_rq;
  logic [31:0]  dcw_in_addr;
  logic [15:0]  dcw_in_mask;
  logic [127:0] dcw_in_data;
  logic         dcw_finish_wresp;
  logic         dcr_start_rq;
  logic [31:0]  dcr_rin_addr;
  logic         rqfull_1;
  logic [127:0] rdat_m_data;
  logic         rdat_m_valid;
  logic         finish_mrd;
  logic         busy;
  logic         ovf_err;

  modport master (
    output dcw_start_rq, dcw_in_addr, dcw_in_mask, dcw_in_data,
    output dcr_start_rq, dcr_rin_addr, rqfull_1,
    input  dcw_finish_wresp, rdat_m_data, rdat_m_valid, finish_mrd, busy, ovf_err
  );

  modport slave (
    input  dcw_start_rq, dcw_in_addr, dcw_in_mask, dcw_in_data,
    input  dcr_start_rq, dcr_rin_addr, rqfull_1,
    output dcw_finish_wresp, rdat_m_data, rdat_m_valid, finish_mrd, busy, ovf_err
  );
endinterface

// File: rtl/dc_mem_responder.sv
// Target end of the D-cache bus: serves 128-bit line writebacks and line fills
// from an internal line-wide RAM, one transaction at a time, with one pending
// slot per channel.
// Ports:
//   clk   : clock
//   rst_n : async active-low reset (aborts any transaction, clears pending slots)
//   bus   : dc_mem_responder_if.slave (requests in, responses/status out)
module dc_mem_responder #(
  parameter int unsigned MWIDTH = 12,
  parameter int unsigned RD_LAT = 4,
  parameter int unsigned WR_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dc_mem_responder_if.slave bus
);

  localparam int unsigned DEPTH   = 1 << MWIDTH;
  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int unsigned LINE_W  = 128;
  localparam int unsigned MASK_W  = 16;

  typedef enum logic [2:0] {IDLE, WLAT, WRSP, RLAT, RHLD, RFIN} state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;

  logic                wp_vld_q, wp_vld_n;
  logic [MWIDTH-1:0]   wp_idx_q, wp_idx_n;
  logic [MASK_W-1:0]   wp_mask_q, wp_mask_n;
  logic [LINE_W-1:0]   wp_data_q, wp_data_n;
  logic                rp_vld_q, rp_vld_n;
  logic [MWIDTH-1:0]   rp_idx_q, rp_idx_n;

  logic [MWIDTH-1:0]   cur_idx_q, cur_idx_n;
  logic [MASK_W-1:0]   cur_mask_q, cur_mask_n;
  logic [LINE_W-1:0]   cur_data_q, cur_data_n;

  logic                ovf_q, ovf_n;
  logic                wresp_q, finish_q, busy_q;
  logic [LINE_W-1:0]   rdat_q;

  logic                mem_we, rd_load;
  logic                w_live_taken, r_live_taken;
  logic [MWIDTH-1:0]   w_live_idx, r_live_idx;

  logic [LINE_W-1:0]   mem [DEPTH];

  // Upper address bits wrap silently; byte-offset bits are ignored.
  assign w_live_idx = bus.dcw_in_addr[MWIDTH+3:4];
  assign r_live_idx = bus.dcr_rin_addr[MWIDTH+3:4];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.dcw_in_addr[31:MWIDTH+4], bus.dcw_in_addr[3:0],
                              bus.dcr_rin_addr[31:MWIDTH+4], bus.dcr_rin_addr[3:0]};

  // Next-state, slot bookkeeping and RAM strobes.
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    wp_vld_n     = wp_vld_q;
    wp_idx_n     = wp_idx_q;
    wp_mask_n    = wp_mask_q;
    wp_data_n    = wp_data_q;
    rp_vld_n     = rp_vld_q;
    rp_idx_n     = rp_idx_q;
    cur_idx_n    = cur_idx_q;
    cur_mask_n   = cur_mask_q;
    cur_data_n   = cur_data_q;
    ovf_n        = ovf_q;
    mem_we       = 1'b0;
    rd_load      = 1'b0;
    w_live_taken = 1'b0;
    r_live_taken = 1'b0;

    case (state_q)
      IDLE: begin
        // Writes win over reads; a pending request is older than a live one.
        if (wp_vld_q || bus.dcw_start_rq) begin
          state_n = WLAT;
          cnt_n   = CNT_W'(WR_LAT - 1);
          if (wp_vld_q) begin
            cur_idx_n  = wp_idx_q;
            cur_mask_n = wp_mask_q;
            cur_data_n = wp_data_q;
            wp_vld_n   = 1'b0;
          end else begin
            cur_idx_n    = w_live_idx;
            cur_mask_n   = bus.dcw_in_mask;
            cur_data_n   = bus.dcw_in_data;
            w_live_taken = 1'b1;
          end
        end else if (rp_vld_q || bus.dcr_start_rq) begin
          state_n = RLAT;
          cnt_n   = CNT_W'(RD_LAT - 1);
          if (rp_vld_q) begin
            cur_idx_n = rp_idx_q;
            rp_vld_n  = 1'b0;
          end else begin
            cur_idx_n    = r_live_idx;
            r_live_taken = 1'b1;
          end
        end
      end
      WLAT: begin
        if (cnt_q == '0) begin
          state_n = WRSP;
          mem_we  = 1'b1;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      WRSP: state_n = IDLE;
      RLAT: begin
        if (cnt_q == '0) begin
          state_n = RHLD;
          rd_load = 1'b1;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      RHLD: if (!bus.rqfull_1) state_n = RFIN;
      RFIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Live requests not served directly park in their slot (freed this
    // cycle or already empty); otherwise they are dropped.
    if (bus.dcw_start_rq && !w_live_taken) begin
      if (!wp_vld_n) begin
        wp_vld_n  = 1'b1;
        wp_idx_n  = w_live_idx;
        wp_mask_n = bus.dcw_in_mask;
        wp_data_n = bus.dcw_in_data;
      end else begin
        ovf_n = 1'b1;
      end
    end
    if (bus.dcr_start_rq && !r_live_taken) begin
      if (!rp_vld_n) begin
        rp_vld_n = 1'b1;
        rp_idx_n = r_live_idx;
      end else begin
        ovf_n = 1'b1;
      end
    end
  end

  // State, slots and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wp_vld_q   <= 1'b0;
      wp_idx_q   <= '0;
      wp_mask_q  <= '0;
      wp_data_q  <= '0;
      rp_vld_q   <= 1'b0;
      rp_idx_q   <= '0;
      cur_idx_q  <= '0;
      cur_mask_q <= '0;
      cur_data_q <= '0;
      ovf_q      <= 1'b0;
      wresp_q    <= 1'b0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
      rdat_q     <= '0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      wp_vld_q   <= wp_vld_n;
      wp_idx_q   <= wp_idx_n;
      wp_mask_q  <= wp_mask_n;
      wp_data_q  <= wp_data_n;
      rp_vld_q   <= rp_vld_n;
      rp_idx_q   <= rp_idx_n;
      cur_idx_q  <= cur_idx_n;
      cur_mask_q <= cur_mask_n;
      cur_data_q <= cur_data_n;
      ovf_q      <= ovf_n;
      wresp_q    <= (state_n == WRSP);
      finish_q   <= (state_n == RFIN);
      busy_q     <= (state_n != IDLE) || wp_vld_n || rp_vld_n;
      if (rd_load) rdat_q <= mem[cur_idx_q];
    end
  end

  // Backing RAM, byte-masked line write (mask bit set = keep old byte).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (!cur_mask_q[i]) mem[cur_idx_q][8*i +: 8] <= cur_data_q[8*i +: 8];
      end
    end
  end

  assign bus.dcw_finish_wresp = wresp_q;
  assign bus.finish_mrd       = finish_q;
  assign bus.busy             = busy_q;
  assign bus.ovf_err          = ovf_q;
  assign bus.rdat_m_data      = rdat_q;
  // Valid follows backpressure directly so it never lingers past one cycle.
  assign bus.rdat_m_valid     = (state_q == RHLD) && !bus.rqfull_1;

endmodule

// File: tb/tb_dc_mem_responder.sv
// Directed bench for dc_mem_responder (MWIDTH=12, RD_LAT=4, WR_LAT=2).
// Cycle numbering: the request is sampled at the end of cycle 0; outputs are
// sampled at the falling edge in the middle of each following cycle.
module tb_dc_mem_responder;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   cyc_n;

  localparam logic [127:0] D1 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] D3 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D4 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D5 = 128'hA5A5A5A5_5A5A5A5A_00FF00FF_FF00FF00;

  dc_mem_responder_if bus ();

  dc_mem_responder #(.MWIDTH(12), .RD_LAT(4), .WR_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc_n++;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.dcw_finish_wresp;
      1:       return bus.rdat_m_valid;
      default: return bus.finish_mrd;
    endcase
  endfunction

  // Steps until the selected output is high; lat = cycle number relative to c.
  task automatic wait_for(input int sel, input int c, output int lat);
    bit found;
    found = 1'b0;
    lat   = -1;
    for (int k = 0; k < 40 && !found; k++) begin
      if (sig(sel)) begin
        found = 1'b1;
        lat   = cyc_n - c;
      end else begin
        step();
      end
    end
  endtask

  task automatic idle_bus();
    bus.dcw_start_rq = 1'b0;
    bus.dcr_start_rq = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [15:0] m,
                          input logic [127:0] d);
    int c, lat;
    c = cyc_n;
    bus.dcw_start_rq = 1'b1;
    bus.dcw_in_addr  = a;
    bus.dcw_in_mask  = m;
    bus.dcw_in_data  = d;
    step();
    idle_bus();
    wait_for(0, c, lat);
    check({tag, "_wresp_lat"}, 128'(lat), 128'd3);
    step();
    check({tag, "_wresp_one"}, 128'(bus.dcw_finish_wresp), 128'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [127:0] exp);
    int c, lat;
    c = cyc_n;
    bus.dcr_start_rq = 1'b1;
    bus.dcr_rin_addr = a;
    step();
    idle_bus();
    wait_for(1, c, lat);
    check({tag, "_valid_lat"}, 128'(lat), 128'd5);
    check({tag, "_data"}, bus.rdat_m_data, exp);
    step();
    check({tag, "_valid_one"}, 128'(bus.rdat_m_valid), 128'd0);
    check({tag, "_finish"}, 128'(bus.finish_mrd), 128'd1);
    step();
  endtask

  initial begin
    int c, lat, nv, nf;
    n_tests = 0;
    n_fail  = 0;
    cyc_n   = 0;
    rst_n   = 1'b0;
    bus.dcw_start_rq = 1'b0;
    bus.dcw_in_addr  = '0;
    bus.dcw_in_mask  = '0;
    bus.dcw_in_data  = '0;
    bus.dcr_start_rq = 1'b0;
    bus.dcr_rin_addr = '0;
    bus.rqfull_1     = 1'b0;
    step();
    step();
    check("rst_outs", {bus.dcw_finish_wresp, bus.rdat_m_valid, bus.finish_mrd,
                       bus.busy, bus.ovf_err}, '0);
    check("rst_rdat", bus.rdat_m_data, '0);
    rst_n = 1'b1;
    step();

    // 1: full-line write then readback
    do_write("t1", 32'h0000_0100, 16'h0000, D1);
    do_read("t1", 32'h0000_0100, D1);

    // 2: masked write keeps masked bytes
    do_write("t2a", 32'h0000_0200, 16'h0000, {16{8'hAA}});
    do_write("t2b", 32'h0000_0200, 16'hFFF0, {16{8'h55}});
    do_read("t2", 32'h0000_0200, {{12{8'hAA}}, {4{8'h55}}});

    // 3: simultaneous write and read to the same line
    do_write("t3a", 32'h0000_0300, 16'h0000, D4);
    c = cyc_n;
    bus.dcw_start_rq = 1'b1;
    bus.dcw_in_addr  = 32'h0000_0300;
    bus.dcw_in_mask  = 16'h0000;
    bus.dcw_in_data  = D3;
    bus.dcr_start_rq = 1'b1;
    bus.dcr_rin_addr = 32'h0000_0300;
    step();
    idle_bus();
    check("t3_busy", 128'(bus.busy), 128'd1);
    check("t3_no_early_valid", 128'(bus.rdat_m_valid), 128'd0);
    wait_for(0, c, lat);
    check("t3_wresp_lat", 128'(lat), 128'd3);
    wait_for(1, c, lat);
    check("t3_valid_lat", 128'(lat), 128'd9);
    check("t3_data", bus.rdat_m_data, D3);
    step();
    check("t3_valid_one", 128'(bus.rdat_m_valid), 128'd0);
    check("t3_finish", 128'(bus.finish_mrd), 128'd1);
    step();

    // 4: backpressure holds data, single valid pulse on release
    bus.rqfull_1 = 1'b1;
    c = cyc_n;
    bus.dcr_start_rq = 1'b1;
    bus.dcr_rin_addr = 32'h0000_0100;
    step();
    idle_bus();
    nv = 0;
    while (cyc_n - c < 12) begin
      if (bus.rdat_m_valid) nv++;
      if (cyc_n - c == 5) check("t4_data_early", bus.rdat_m_data, D1);
      step();
    end
    check("t4_no_valid_held", 128'(nv), 128'd0);
    check("t4_data_held", bus.rdat_m_data, D1);
    bus.rqfull_1 = 1'b0;
    #1;
    check("t4_valid_release", 128'(bus.rdat_m_valid), 128'd1);
    step();
    check("t4_valid_one", 128'(bus.rdat_m_valid), 128'd0);
    check("t4_finish", 128'(bus.finish_mrd), 128'd1);
    step();

    // Address wrap and ignored byte offset
    do_write("wrap", 32'hFFFF_0500, 16'h0000, D5);
    do_read("wrap", 32'h0000_050F, D5);

    // 5: two reads while busy; second dropped
    check("t5_ovf_before", 128'(bus.ovf_err), 128'd0);
    c = cyc_n;
    bus.dcw_start_rq = 1'b1;
    bus.dcw_in_addr  = 32'h0000_0400;
    bus.dcw_in_mask  = 16'h0000;
    bus.dcw_in_data  = D4;
    step();
    bus.dcw_start_rq = 1'b0;
    bus.dcr_start_rq = 1'b1;
    bus.dcr_rin_addr = 32'h0000_0300;
    step();
    bus.dcr_rin_addr = 32'h0000_0200;
    step();
    idle_bus();
    check("t5_ovf", 128'(bus.ovf_err), 128'd1);
    wait_for(0, c, lat);
    check("t5_wresp_lat", 128'(lat), 128'd3);
    wait_for(1, c, lat);
    check("t5_valid_lat", 128'(lat), 128'd9);
    check("t5_data_first", bus.rdat_m_data, D3);
    step();
    check("t5_finish", 128'(bus.finish_mrd), 128'd1);
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.rdat_m_valid) nv++;
    end
    check("t5_dropped", 128'(nv), 128'd0);
    check("t5_idle", 128'(bus.busy), 128'd0);
    check("t5_ovf_sticky", 128'(bus.ovf_err), 128'd1);

    // 6: reset during RLAT aborts the read
    c = cyc_n;
    bus.dcr_start_rq = 1'b1;
    bus.dcr_rin_addr = 32'h0000_0100;
    step();
    idle_bus();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("t6_outs", {bus.dcw_finish_wresp, bus.rdat_m_valid, bus.finish_mrd,
                      bus.busy, bus.ovf_err}, '0);
    check("t6_rdat", bus.rdat_m_data, '0);
    step();
    rst_n = 1'b1;
    nv = 0;
    nf = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.rdat_m_valid) nv++;
      if (bus.finish_mrd) nf++;
    end
    check("t6_no_valid", 128'(nv), 128'd0);
    check("t6_no_finish", 128'(nf), 128'd0);

    // Memory content survives reset
    do_read("t6_after", 32'h0000_0100, D1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
